// File: rtl/ttt_pkg.sv
// ttt_pkg: shared state encoding, position layout and helpers for the tic-tac-toe input conditioner.
package ttt_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_DRIVE   = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int NUM_POS  = 4;
    localparam int POS1_BIT = 3;
    localparam int POS2_BIT = 2;
    localparam int POS3_BIT = 1;
    localparam int POS4_BIT = 0;

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/ttt_debounce.sv
// ttt_debounce: 2-flop synchroniser plus consecutive-stable-cycle debounce for one raw key.
module ttt_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic level
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= key;
            s2 <= s1;
            if (s2 == level)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else
                cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/ttt_input_cond.sv
// ttt_input_cond: turns raw player/position keys into a held-then-released move for the game core.
module ttt_input_cond
    import ttt_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 8,
    parameter int ARM_TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_play1,
    input  logic               key_play2,
    input  logic [NUM_POS-1:0] key_pos,
    output logic               play1,
    output logic               play2,
    output logic [NUM_POS-1:0] button,
    output logic               move_done,
    output logic               err_pulse,
    output logic [1:0]         state
);
    localparam int CW = $clog2(imax(HOLD_CYCLES, ARM_TIMEOUT) + 1);

    logic [NUM_POS+1:0] raw, db, db_d1, rise;
    logic               rp1, rp2, one_pos, multi_pos, reselect, player;
    logic [NUM_POS-1:0] rpos;
    logic [CW-1:0]      cnt;
    state_t             st;

    assign raw = {key_play1, key_play2, key_pos};

    for (genvar i = 0; i < NUM_POS + 2; i++) begin : g_key
        ttt_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk   (clk),
            .reset (reset),
            .key   (raw[i]),
            .level (db[i])
        );
    end

    // Only rising edges of the debounced levels start or steer a move.
    assign rise            = db & ~db_d1;
    assign {rp1, rp2, rpos} = rise;
    assign multi_pos       = |(rpos & (rpos - NUM_POS'(1)));
    assign one_pos         = |rpos & ~multi_pos;
    assign reselect        = player ? rp1 : rp2;
    assign state           = st;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_d1     <= '0;
            st        <= ST_IDLE;
            cnt       <= '0;
            player    <= 1'b0;
            play1     <= 1'b0;
            play2     <= 1'b0;
            button    <= '0;
            move_done <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            db_d1     <= db;
            move_done <= 1'b0;
            err_pulse <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (rp1 && rp2)
                        err_pulse <= 1'b1;
                    else if (rp1 || rp2) begin
                        player <= rp2;
                        st     <= ST_ARMED;
                        cnt    <= '0;
                    end
                end
                ST_ARMED: begin
                    if (one_pos) begin
                        st     <= ST_DRIVE;
                        cnt    <= '0;
                        play1  <= ~player;
                        play2  <= player;
                        button <= rpos;
                    end else if (reselect) begin
                        player <= ~player;
                        cnt    <= '0;
                    end else if (cnt == CW'(ARM_TIMEOUT - 1)) begin
                        err_pulse <= 1'b1;
                        st        <= ST_IDLE;
                        cnt       <= '0;
                    end else begin
                        err_pulse <= multi_pos;
                        cnt       <= cnt + CW'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        st     <= ST_RELEASE;
                        cnt    <= '0;
                        play1  <= 1'b0;
                        play2  <= 1'b0;
                        button <= '0;
                    end else begin
                        move_done <= (cnt == CW'(HOLD_CYCLES - 2));
                        cnt       <= cnt + CW'(1);
                    end
                end
                default: begin
                    if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        st  <= ST_IDLE;
                        cnt <= '0;
                    end else
                        cnt <= cnt + CW'(1);
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ttt_input_cond.sv
// tb_ttt_input_cond: segment table, hand-built reset sequence and a randomized run against a behavioural model.
module tb_ttt_input_cond;
    localparam int D = 4;
    localparam int H = 3;
    localparam int A = 20;

    logic       clk = 1'b0, reset = 1'b0, key_play1 = 1'b0, key_play2 = 1'b0;
    logic [3:0] key_pos = 4'h0;
    logic       play1, play2, move_done, err_pulse;
    logic [3:0] button;
    logic [1:0] state;
    int         errors = 0, checks = 0;

    always #5 clk = ~clk;

    ttt_input_cond #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ARM_TIMEOUT(A)) dut (
        .clk       (clk),
        .reset     (reset),
        .key_play1 (key_play1),
        .key_play2 (key_play2),
        .key_pos   (key_pos),
        .play1     (play1),
        .play2     (play2),
        .button    (button),
        .move_done (move_done),
        .err_pulse (err_pulse),
        .state     (state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference: a key's level flips once the synchronised samples
    // have disagreed with it for D consecutive cycles; the move sequencer is
    // tracked as a state plus cycles-spent-in-state.
    logic [5:0] hist [0:D];
    logic [5:0] m_db, m_dbd1;
    int         m_st, m_t;
    logic       m_player, m_err;
    logic [3:0] m_btn;

    task automatic model_reset();
        for (int k = 0; k <= D; k++) hist[k] = 6'h0;
        m_db = 6'h0; m_dbd1 = 6'h0; m_st = 0; m_t = 0;
        m_player = 1'b0; m_err = 1'b0; m_btn = 4'h0;
    endtask

    task automatic model_step(input logic [5:0] raw);
        logic [5:0] rise, flip;
        logic [3:0] rpos;
        rise = m_db & ~m_dbd1;
        rpos = rise[3:0];
        flip = 6'h3f;
        for (int k = 1; k <= D; k++) flip &= hist[k] ^ m_db;
        for (int k = D; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = raw;
        m_dbd1 = m_db;
        m_db = m_db ^ flip;
        m_err = 1'b0;
        if (m_st == 0) begin
            if (rise[5] && rise[4]) m_err = 1'b1;
            else if (rise[5] || rise[4]) begin m_st = 1; m_t = 0; m_player = rise[4]; end
        end else if (m_st == 1) begin
            if ($countones(rpos) == 1) begin m_st = 2; m_t = 0; m_btn = rpos; end
            else if (m_player ? rise[5] : rise[4]) begin m_player = !m_player; m_t = 0; end
            else if (m_t == A - 1) begin m_err = 1'b1; m_st = 0; m_t = 0; end
            else begin m_t++; m_err = ($countones(rpos) >= 2); end
        end else begin
            if (m_t == H - 1) begin m_st = (m_st == 2) ? 3 : 0; m_t = 0; end
            else m_t++;
        end
    endtask

    typedef struct {
        logic       p1, p2;
        logic [3:0] pos;
        int         cyc, st, nerr, ndone, np1, np2;
        logic [3:0] btn;
    } seg_t;
    seg_t segs [18];

    initial begin
        int nerr, ndone, np1, np2, bad;
        logic [3:0] bor;
        logic [9:0] exp_v;
        segs[0]  = '{1'b0, 1'b1, 4'h0,  3, 0, 0, 0, 0, 0, 4'h0};
        segs[1]  = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 0, 0, 0, 4'h0};
        segs[2]  = '{1'b1, 1'b0, 4'h0, 10, 1, 0, 0, 0, 0, 4'h0};
        segs[3]  = '{1'b1, 1'b0, 4'h8, 10, 3, 0, 1, 3, 0, 4'h8};
        segs[4]  = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 0, 0, 0, 4'h0};
        segs[5]  = '{1'b1, 1'b1, 4'h0, 10, 0, 1, 0, 0, 0, 4'h0};
        segs[6]  = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 0, 0, 0, 4'h0};
        segs[7]  = '{1'b0, 1'b1, 4'h0, 30, 0, 1, 0, 0, 0, 4'h0};
        segs[8]  = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 0, 0, 0, 4'h0};
        segs[9]  = '{1'b1, 1'b0, 4'h0,  8, 1, 0, 0, 0, 0, 4'h0};
        segs[10] = '{1'b1, 1'b0, 4'h6,  8, 1, 1, 0, 0, 0, 4'h0};
        segs[11] = '{1'b1, 1'b0, 4'h7, 10, 3, 0, 1, 3, 0, 4'h1};
        segs[12] = '{1'b0, 1'b0, 4'h0, 10, 0, 0, 0, 0, 0, 4'h0};
        segs[13] = '{1'b1, 1'b0, 4'h0,  8, 1, 0, 0, 0, 0, 4'h0};
        segs[14] = '{1'b1, 1'b1, 4'h0,  8, 1, 0, 0, 0, 0, 4'h0};
        segs[15] = '{1'b1, 1'b1, 4'h4, 10, 3, 0, 1, 0, 3, 4'h4};
        segs[16] = '{1'b0, 1'b0, 4'h4, 12, 0, 0, 0, 0, 0, 4'h0};
        segs[17] = '{1'b0, 1'b0, 4'h4, 10, 0, 0, 0, 0, 0, 4'h0};

        repeat (3) tick();
        check("reset_state", {state, play1, play2, button, move_done, err_pulse}, 32'h0);
        reset = 1'b1;

        for (int i = 0; i < 18; i++) begin
            key_play1 = segs[i].p1; key_play2 = segs[i].p2; key_pos = segs[i].pos;
            nerr = 0; ndone = 0; np1 = 0; np2 = 0; bor = 4'h0;
            repeat (segs[i].cyc) begin
                tick();
                nerr += int'(err_pulse); ndone += int'(move_done);
                np1 += int'(play1); np2 += int'(play2); bor |= button;
            end
            check($sformatf("seg%0d_state", i), state, segs[i].st);
            check($sformatf("seg%0d_err", i), nerr, segs[i].nerr);
            check($sformatf("seg%0d_done", i), ndone, segs[i].ndone);
            check($sformatf("seg%0d_play1", i), np1, segs[i].np1);
            check($sformatf("seg%0d_play2", i), np2, segs[i].np2);
            check($sformatf("seg%0d_button", i), bor, segs[i].btn);
        end

        key_play1 = 1'b0; key_play2 = 1'b0; key_pos = 4'h0;
        repeat (10) tick();
        key_play1 = 1'b1;
        repeat (8) tick();
        key_pos = 4'h8;
        repeat (7) tick();
        check("drive_before_reset", {state, play1, play2, button}, {2'd2, 1'b1, 1'b0, 4'h8});
        #2 reset = 1'b0;
        #1 check("async_reset_outputs", {state, play1, play2, button, move_done, err_pulse}, 32'h0);
        key_play1 = 1'b0; key_pos = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        bad = 0;
        repeat (20) begin
            tick();
            if (state != 2'd0 || play1 || play2 || button != 4'h0) bad++;
        end
        check("idle_after_reset", bad, 0);

        model_reset();
        for (int s = 0; s < 160; s++) begin
            int r;
            key_play1 = ($urandom_range(0, 3) == 0);
            key_play2 = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 19);
            key_pos = (r < 10) ? 4'h0 : (r < 17) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            repeat ($urandom_range(1, 14)) begin
                @(posedge clk);
                model_step({key_play1, key_play2, key_pos});
                #1;
                exp_v = {2'(m_st), m_st == 2 && !m_player, m_st == 2 && m_player,
                         (m_st == 2) ? m_btn : 4'h0, m_st == 2 && m_t == H - 1, m_err};
                check($sformatf("rand%0d", s), {state, play1, play2, button, move_done, err_pulse}, exp_v);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
